sram_like_arbiter: RTL and testbench
====================================

// Module: sram_like_arbiter
// PURPOSE
//  Sits directly downstream of the CPU core's instruction and data ports. Merges the
//  IF-stage fetch channel and the EXE/MEM-stage load/store channel onto one
//  single-ported synchronous SRAM.
//  Both channels use a req/addr_ok/data_ok handshake; at most one access is in flight.
//  Data channel has priority; a starvation counter guarantees fetch progress.
// PARAMETERS
//  ADDR_W        32  address width, both channels and memory
//  DATA_W        32  data width; the write strobe is DATA_W/8 bits
//  STARVE_LIMIT  4   consecutive denied inst-request cycles before inst wins one grant (>=1)
// PORTS
//  clk               in   1            clock, all state on rising edge
//  resetn            in   1            asynchronous active-low reset
//  inst_sram_req     in   1            fetch request (read only); held until addr_ok
//  inst_sram_addr    in   ADDR_W       fetch address
//  inst_sram_addr_ok out  1            fetch request accepted this cycle
//  inst_sram_data_ok out  1            fetch data valid this cycle (1-cycle pulse)
//  inst_sram_rdata   out  DATA_W       fetch data
//  inst_cancel       in   1            flush: drop the outstanding fetch response
//  data_sram_req     in   1            load/store request; held until addr_ok
//  data_sram_wr      in   1            1 = store, 0 = load
//  data_sram_wstrb   in   DATA_W/8     byte strobes for a store
//  data_sram_addr    in   ADDR_W       load/store address
//  data_sram_wdata   in   DATA_W       store data
//  data_sram_addr_ok out  1            load/store accepted this cycle
//  data_sram_data_ok out  1            load data / store completion, 1-cycle pulse
//  data_sram_rdata   out  DATA_W       load data
//  mem_en            out  1            memory enable
//  mem_we            out  DATA_W/8     memory byte write enables
//  mem_addr          out  ADDR_W       memory address
//  mem_wdata         out  DATA_W       memory write data
//  mem_rdata         in   DATA_W       memory read data, valid the cycle after mem_en
// BEHAVIOUR
//  Grant, combinational in cycle T:
//  - data_sram_req wins unless starve_cnt == STARVE_LIMIT and inst_sram_req is 1.
//    In that case inst wins.
//  - Winner gets addr_ok=1 in T. mem_en=1, mem_addr=winner addr in T.
//  - mem_we = (data winner & data_sram_wr) ? wstrb : 0. mem_wdata = data_sram_wdata.
//  - No request: mem_en=0, mem_we=0, both addr_ok=0.
//  Response FSM, owner_q in {NONE, INST, DATA}:
//  - On grant, owner_q <= winner. Otherwise owner_q <= NONE.
//  - In T+1: owner_q==DATA gives data_sram_data_ok=1.
//  - In T+1: owner_q==INST & ~drop_q gives inst_sram_data_ok=1.
//  - Fixed latency 1. A new grant is legal in the same cycle as data_ok, so
//    throughput is 1 access/cycle.
//  - inst_sram_rdata = data_sram_rdata = mem_rdata. Values are only meaningful with
//    data_ok. Store data_ok carries no data.
//  Cancel:
//  - drop_q <= inst_cancel & (owner_q==INST | inst grant this cycle).
//  - Cancel in the same cycle as inst data_ok does not suppress that pulse.
//  - Cancel never blocks a new grant.
//  Starvation counter, width $clog2(STARVE_LIMIT+1), saturating:
//  - Increments when inst_sram_req=1 and inst is not granted.
//  - Clears to 0 on any inst grant, or when inst_sram_req=0.
//  Reset (resetn=0, async): owner_q=NONE, drop_q=0, starve_cnt=0.
//  - While resetn=0, all addr_ok, data_ok, mem_en and mem_we are 0.
//  - Reset mid-access discards that response. No data_ok follows release of reset.
//  - First grant is possible in the first cycle with resetn=1.
//  Requests that drop before addr_ok are legal and produce nothing. The bridge never
//  asserts two data_ok in one cycle.
// TESTING
//  1. Reset asserted mid-load (owner_q=DATA) -> after release no data_ok; all outputs 0 while resetn=0.
//  2. inst req addr=0x1c000000, mem holds 0x02800c0c -> addr_ok T, mem_en T, inst data_ok T+1 rdata=0x02800c0c.
//  3. Both req in T, data load addr=0x100 -> data_addr_ok=1, inst_addr_ok=0; data_data_ok T+1; inst granted T+1, data_ok T+2.
//  4. data_req held high 6 cycles, inst_req high, STARVE_LIMIT=4 -> inst granted in the 5th cycle; data resumes in the 6th.
//  5. Store wstrb=4'b0011 addr=0x200 wdata=0xAABBCCDD, then load 0x200 (old 0x11223344) -> mem_we=0011 in T; load returns 0x1122CCDD.
//  6. inst granted T, inst_cancel=1 in T -> no inst data_ok in T+1; an inst grant in T+1 returns data_ok in T+2.

Source files
------------

// File: rtl/sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_arbiter
// Purpose  : Merges the CPU fetch channel and load/store channel onto a single
//            single-ported synchronous SRAM. Data has priority; a saturating
//            starvation counter forces an occasional fetch grant. At most one
//            access is in flight, with a fixed one-cycle response latency.
// Revision : 1.0 - initial release
// ============================================================================
module sram_like_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                resetn,
  // fetch channel
  input  logic                inst_sram_req,
  input  logic [ADDR_W-1:0]   inst_sram_addr,
  output logic                inst_sram_addr_ok,
  output logic                inst_sram_data_ok,
  output logic [DATA_W-1:0]   inst_sram_rdata,
  input  logic                inst_cancel,
  // load/store channel
  input  logic                data_sram_req,
  input  logic                data_sram_wr,
  input  logic [DATA_W/8-1:0] data_sram_wstrb,
  input  logic [ADDR_W-1:0]   data_sram_addr,
  input  logic [DATA_W-1:0]   data_sram_wdata,
  output logic                data_sram_addr_ok,
  output logic                data_sram_data_ok,
  output logic [DATA_W-1:0]   data_sram_rdata,
  // memory side
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int c_STRB_W = DATA_W / 8;
  localparam int c_CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  // Owner of the access currently waiting for its response.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  owner_t               r_owner;
  owner_t               w_owner_nxt;
  logic                 r_drop;
  logic                 w_drop_nxt;
  logic [c_CNT_W-1:0]   r_starve_cnt;
  logic [c_CNT_W-1:0]   w_starve_nxt;
  logic                 w_inst_win;
  logic                 w_data_win;

  // State register: response owner, fetch-drop flag and starvation counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_owner      <= OWN_NONE;
      r_drop       <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      r_owner      <= w_owner_nxt;
      r_drop       <= w_drop_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // Grant decision and next-state logic; grants are masked while in reset.
  always_comb begin
    w_inst_win   = 1'b0;
    w_data_win   = 1'b0;
    w_owner_nxt  = OWN_NONE;
    w_drop_nxt   = 1'b0;
    w_starve_nxt = r_starve_cnt;

    // Fetch wins when it is alone, or when it has waited long enough.
    w_inst_win = resetn & inst_sram_req &
                 (~data_sram_req | (r_starve_cnt == c_LIMIT));
    w_data_win = resetn & data_sram_req & ~w_inst_win;

    if (w_inst_win) begin
      w_owner_nxt = OWN_INST;
    end else if (w_data_win) begin
      w_owner_nxt = OWN_DATA;
    end

    // A flush drops the fetch response that is pending or being granted now.
    w_drop_nxt = inst_cancel & ((r_owner == OWN_INST) | w_inst_win);

    if (!inst_sram_req || w_inst_win) begin
      w_starve_nxt = '0;
    end else if (r_starve_cnt != c_LIMIT) begin
      w_starve_nxt = r_starve_cnt + c_ONE;
    end
  end

  // Memory request side and channel handshakes driven from the grant.
  always_comb begin
    inst_sram_addr_ok = w_inst_win;
    data_sram_addr_ok = w_data_win;
    mem_en            = w_inst_win | w_data_win;
    mem_addr          = w_inst_win ? inst_sram_addr : data_sram_addr;
    mem_wdata         = data_sram_wdata;
    mem_we            = {c_STRB_W{1'b0}};
    if (w_data_win && data_sram_wr) begin
      mem_we = data_sram_wstrb;
    end
  end

  // Responses: one-cycle latency after the grant, read data passed straight through.
  always_comb begin
    inst_sram_data_ok = (r_owner == OWN_INST) & ~r_drop;
    data_sram_data_ok = (r_owner == OWN_DATA);
    inst_sram_rdata   = mem_rdata;
    data_sram_rdata   = mem_rdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_like_arbiter
// Purpose  : Directed self-checking bench for sram_like_arbiter with a
//            behavioural SRAM and a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_like_arbiter;

  localparam int c_RESP_NONE  = 0;
  localparam int c_RESP_INST  = 1;
  localparam int c_RESP_LOAD  = 2;
  localparam int c_RESP_STORE = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        inst_cancel;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  typedef struct {
    int          chan;
    logic [31:0] data;
  } resp_t;

  resp_t       sb[$];
  logic [31:0] mem [logic [31:0]];
  int          total = 0;
  int          bad   = 0;

  sram_like_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .inst_sram_req    (inst_sram_req),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata  (inst_sram_rdata),
    .inst_cancel      (inst_cancel),
    .data_sram_req    (data_sram_req),
    .data_sram_wr     (data_sram_wr),
    .data_sram_wstrb  (data_sram_wstrb),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata  (data_sram_rdata),
    .mem_en           (mem_en),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous SRAM: read data one cycle after the enable.
  always @(posedge clk) begin
    logic [31:0] word;
    if (mem_en) begin
      word = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
      mem_rdata <= word;
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) word[8*b +: 8] = mem_wdata[8*b +: 8];
      end
      if (mem_we != 4'b0000) mem[mem_addr] = word;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs already driven at the falling edge. Check the grant side,
  // check the response owed from the previous cycle, then queue this cycle's.
  task automatic tick(input logic eia, input logic eda, input logic een,
                      input logic [3:0] ewe, input logic [31:0] eaddr,
                      input int pchan, input logic [31:0] pdata);
    resp_t r;
    #1;
    chk("inst_addr_ok", {31'b0, inst_sram_addr_ok}, {31'b0, eia});
    chk("data_addr_ok", {31'b0, data_sram_addr_ok}, {31'b0, eda});
    chk("mem_en", {31'b0, mem_en}, {31'b0, een});
    chk("mem_we", {28'b0, mem_we}, {28'b0, ewe});
    if (een) chk("mem_addr", mem_addr, eaddr);
    if (sb.size() > 0) r = sb.pop_front();
    else begin
      r.chan = c_RESP_NONE;
      r.data = '0;
    end
    chk("inst_data_ok", {31'b0, inst_sram_data_ok}, {31'b0, (r.chan == c_RESP_INST)});
    chk("data_data_ok", {31'b0, data_sram_data_ok},
        {31'b0, (r.chan == c_RESP_LOAD || r.chan == c_RESP_STORE)});
    if (r.chan == c_RESP_INST) chk("inst_rdata", inst_sram_rdata, r.data);
    if (r.chan == c_RESP_LOAD) chk("data_rdata", data_sram_rdata, r.data);
    r.chan = pchan;
    r.data = pdata;
    sb.push_back(r);
    @(negedge clk);
  endtask

  initial begin
    mem[32'h1c000000] = 32'h02800c0c;
    mem[32'h1c000004] = 32'h12345678;
    mem[32'h00000100] = 32'hcafef00d;
    mem[32'h00000200] = 32'h11223344;

    resetn          = 1'b0;
    inst_sram_req   = 1'b1;
    inst_sram_addr  = 32'h1c000000;
    inst_cancel     = 1'b0;
    data_sram_req   = 1'b1;
    data_sram_wr    = 1'b1;
    data_sram_wstrb = 4'hf;
    data_sram_addr  = 32'h100;
    data_sram_wdata = 32'hdeadbeef;
    @(negedge clk);

    // Held in reset with both requests up: everything stays quiet.
    tick(0, 0, 0, 4'h0, 32'h0, c_RESP_NONE, 32'h0);
    tick(0, 0, 0, 4'h0, 32'h0, c_RESP_NONE, 32'h0);

    // Load granted in the first cycle out of reset, then reset hits mid-load.
    sb.delete();
    resetn        = 1'b1;
    inst_sram_req = 1'b0;
    data_sram_wr  = 1'b0;
    #1;
    chk("first_grant_data_addr_ok", {31'b0, data_sram_addr_ok}, 32'd1);
    chk("first_grant_mem_en", {31'b0, mem_en}, 32'd1);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("rst_data_data_ok", {31'b0, data_sram_data_ok}, 32'd0);
    chk("rst_data_addr_ok", {31'b0, data_sram_addr_ok}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    @(negedge clk);
    resetn        = 1'b1;
    data_sram_req = 1'b0;
    tick(0, 0, 0, 4'h0, 32'h0, c_RESP_NONE, 32'h0);
    tick(0, 0, 0, 4'h0, 32'h0, c_RESP_NONE, 32'h0);

    // Plain fetch.
    inst_sram_req = 1'b1;
    tick(1, 0, 1, 4'h0, 32'h1c000000, c_RESP_INST, 32'h02800c0c);
    inst_sram_req = 1'b0;
    tick(0, 0, 0, 4'h0, 32'h0, c_RESP_NONE, 32'h0);

    // Both request: data first, fetch follows back to back.
    inst_sram_req  = 1'b1;
    data_sram_req  = 1'b1;
    data_sram_addr = 32'h100;
    tick(0, 1, 1, 4'h0, 32'h100, c_RESP_LOAD, 32'hcafef00d);
    data_sram_req = 1'b0;
    tick(1, 0, 1, 4'h0, 32'h1c000000, c_RESP_INST, 32'h02800c0c);
    inst_sram_req = 1'b0;
    tick(0, 0, 0, 4'h0, 32'h0, c_RESP_NONE, 32'h0);

    // Starvation: fetch forced through on the 5th cycle of contention.
    inst_sram_req = 1'b1;
    data_sram_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 1, 4'h0, 32'h100, c_RESP_LOAD, 32'hcafef00d);
    end
    tick(1, 0, 1, 4'h0, 32'h1c000000, c_RESP_INST, 32'h02800c0c);
    tick(0, 1, 1, 4'h0, 32'h100, c_RESP_LOAD, 32'hcafef00d);
    inst_sram_req = 1'b0;
    data_sram_req = 1'b0;
    tick(0, 0, 0, 4'h0, 32'h0, c_RESP_NONE, 32'h0);

    // Partial store then read-back; load keeps the strobe bus nonzero.
    data_sram_req   = 1'b1;
    data_sram_wr    = 1'b1;
    data_sram_wstrb = 4'b0011;
    data_sram_addr  = 32'h200;
    data_sram_wdata = 32'haabbccdd;
    tick(0, 1, 1, 4'b0011, 32'h200, c_RESP_STORE, 32'h0);
    data_sram_wr = 1'b0;
    tick(0, 1, 1, 4'h0, 32'h200, c_RESP_LOAD, 32'h1122ccdd);
    data_sram_req = 1'b0;
    tick(0, 0, 0, 4'h0, 32'h0, c_RESP_NONE, 32'h0);

    // Cancel in the grant cycle drops that fetch; the next fetch returns.
    inst_sram_req = 1'b1;
    inst_cancel   = 1'b1;
    tick(1, 0, 1, 4'h0, 32'h1c000000, c_RESP_NONE, 32'h0);
    inst_cancel    = 1'b0;
    inst_sram_addr = 32'h1c000004;
    tick(1, 0, 1, 4'h0, 32'h1c000004, c_RESP_INST, 32'h12345678);
    inst_sram_req = 1'b0;
    tick(0, 0, 0, 4'h0, 32'h0, c_RESP_NONE, 32'h0);

    // Cancel in the data_ok cycle does not suppress the pulse.
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1c000000;
    tick(1, 0, 1, 4'h0, 32'h1c000000, c_RESP_INST, 32'h02800c0c);
    inst_sram_req = 1'b0;
    inst_cancel   = 1'b1;
    tick(0, 0, 0, 4'h0, 32'h0, c_RESP_NONE, 32'h0);
    inst_cancel = 1'b0;
    tick(0, 0, 0, 4'h0, 32'h0, c_RESP_NONE, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
